// File: rtl/rename_queue_if.sv
// Decoder-to-queue and queue-to-Rename signal bundle.
// slave = the queue; master = decoder/Rename side.
interface rename_queue_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          id_valid;
  logic [31:0]   id_instr;
  logic [31:0]   id_instrpc;
  logic [4:0]    id_RegA;
  logic [4:0]    id_RegB;
  logic [4:0]    id_RegWr;
  logic [87:0]   id_control;
  logic          halt_rename_queue;

  logic          rq_full;
  logic          rq_almost_full;
  logic [CW-1:0] rq_count;
  logic          rq_valid;
  logic [31:0]   rq_instr;
  logic [31:0]   rq_instrpc;
  logic [4:0]    rq_RegA;
  logic [4:0]    rq_RegB;
  logic [4:0]    rq_RegWr;
  logic [87:0]   rq_control;

  modport slave (
    input  id_valid, id_instr, id_instrpc,
    input  id_RegA, id_RegB, id_RegWr,
    input  id_control, halt_rename_queue,
    output rq_full, rq_almost_full, rq_count,
    output rq_valid, rq_instr, rq_instrpc,
    output rq_RegA, rq_RegB, rq_RegWr,
    output rq_control
  );

  modport master (
    output id_valid, id_instr, id_instrpc,
    output id_RegA, id_RegB, id_RegWr,
    output id_control, halt_rename_queue,
    input  rq_full, rq_almost_full, rq_count,
    input  rq_valid, rq_instr, rq_instrpc,
    input  rq_RegA, rq_RegB, rq_RegWr,
    input  rq_control
  );
endinterface

// File: rtl/rename_queue.sv
// In-order FWFT queue between decode and Rename.
// Define RENAME_QUEUE_BYPASS_EN for the empty-queue bypass path.
module rename_queue #(
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = DEPTH - 2
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          FLUSH,
  rename_queue_if.slave rq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rega;
    logic [4:0]  regb;
    logic [4:0]  regwr;
    logic [87:0] control;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  entry_t wr_e, head_e, out_e;
  logic   full, empty, valid;
  logic   enq, deq, byp, wr, pop;

  assign wr_e = '{
    instr:   rq.id_instr,
    pc:      rq.id_instrpc,
    rega:    rq.id_RegA,
    regb:    rq.id_RegB,
    regwr:   rq.id_RegWr,
    control: rq.id_control
  };

  always_comb begin
    full   = (count_q == FULL_C);
    empty  = (count_q == '0);
    enq    = rq.id_valid & ~full;
    byp    = 1'b0;
    head_e = mem_q[head_q];
    valid  = ~empty;
`ifdef RENAME_QUEUE_BYPASS_EN
    if (empty && !FLUSH && rq.id_valid) begin
      byp    = 1'b1;
      head_e = wr_e;
      valid  = 1'b1;
    end
`endif
    deq = valid & ~rq.halt_rename_queue;
    // a bypassed entry taken by Rename never lands in the array
    wr  = enq & ~(byp & deq);
    pop = deq & ~byp;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (FLUSH) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr) begin
        mem_d[tail_q] = wr_e;
        tail_d        = tail_q + AW'(1);
      end
      if (pop) head_d = head_q + AW'(1);
      unique case ({wr, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign out_e = valid ? head_e : '0;

  assign rq.rq_full        = full;
  assign rq.rq_almost_full = (count_q >= AFULL_C);
  assign rq.rq_count       = count_q;
  assign rq.rq_valid       = valid;
  assign rq.rq_instr       = out_e.instr;
  assign rq.rq_instrpc     = out_e.pc;
  assign rq.rq_RegA        = out_e.rega;
  assign rq.rq_RegB        = out_e.regb;
  assign rq.rq_RegWr       = out_e.regwr;
  assign rq.rq_control     = out_e.control;
endmodule
